// File: rtl/sync_fifo_occ_pkg.sv
// Shared types and helpers for the FIFO occupancy tracker.
//   occ_cnt_w   : width of a count that must hold the values 0..depth
//   occ_flags_t : per-channel status decode (full/empty/almost_full/almost_empty)
//   occ_clamp_e : result of clamping the next count to the range 0..DEPTH
package sync_fifo_occ_pkg;

    function automatic int unsigned occ_cnt_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    typedef struct packed {
        logic full;
        logic empty;
        logic af;
        logic ae;
    } occ_flags_t;

    typedef enum logic [1:0] {
        OCC_OK,
        OCC_OVF,
        OCC_UNF
    } occ_clamp_e;

endpackage

// File: rtl/sync_fifo_occ_channel.sv
// One occupancy channel: bounded count, sticky overflow/underflow, flag decode.
// State updates on the falling clk edge; reset is asynchronous, active-high.
// Optional macro SYNC_FIFO_OCC_PEAK_EN adds a running-maximum register.
// Ports:
//   clk, reset          clock (falling edge) and async active-high reset
//   clr                 synchronous clear of count and sticky bits
//   inc/inc_amt         add inc_amt when inc is set
//   dec/dec_amt         subtract dec_amt when dec is set
//   count               current occupancy (0..DEPTH)
//   flags               combinational decode of count
//   overflow/underflow  sticky clamp indicators
//   peak                (SYNC_FIFO_OCC_PEAK_EN only) max count since reset/clr
module sync_fifo_occ_channel
    import sync_fifo_occ_pkg::*;
#(
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned STEP_W   = 3,
    parameter int          AF_LEVEL = 14,
    parameter int          AE_LEVEL = 2,
    parameter int unsigned CNT_W    = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              inc,
    input  logic [STEP_W-1:0] inc_amt,
    input  logic              dec,
    input  logic [STEP_W-1:0] dec_amt,
    output logic [CNT_W-1:0]  count,
    output occ_flags_t        flags,
    output logic              overflow,
    output logic              underflow
`ifdef SYNC_FIFO_OCC_PEAK_EN
    ,
    output logic [CNT_W-1:0]  peak
`endif
);

    // One extra bit over count+step keeps the signed sum from wrapping.
    localparam int unsigned SUM_W = CNT_W + STEP_W + 1;
    localparam logic signed [SUM_W-1:0] DEPTH_S = SUM_W'(DEPTH);

    logic [CNT_W-1:0]        count_q, count_d;
    logic                    ovf_q, unf_q;
    logic signed [SUM_W-1:0] sum;
    occ_clamp_e              clamp;

    always_comb begin
        sum = SUM_W'(count_q);
        if (inc) sum = sum + SUM_W'(inc_amt);
        if (dec) sum = sum - SUM_W'(dec_amt);

        clamp   = OCC_OK;
        count_d = sum[CNT_W-1:0];
        if (sum[SUM_W-1]) begin
            clamp   = OCC_UNF;
            count_d = '0;
        end else if (sum > DEPTH_S) begin
            clamp   = OCC_OVF;
            count_d = CNT_W'(DEPTH);
        end
    end

    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else if (clr) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            if (clamp == OCC_OVF) ovf_q <= 1'b1;
            if (clamp == OCC_UNF) unf_q <= 1'b1;
        end
    end

`ifdef SYNC_FIFO_OCC_PEAK_EN
    logic [CNT_W-1:0] peak_q;

    // Tracks the post-clamp value, so it never exceeds DEPTH.
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            peak_q <= '0;
        end else if (clr) begin
            peak_q <= '0;
        end else if (count_d > peak_q) begin
            peak_q <= count_d;
        end
    end

    assign peak = peak_q;
`endif

    assign count     = count_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;

    always_comb begin
        flags.full  = (count_q == CNT_W'(DEPTH));
        flags.empty = (count_q == '0);
        flags.af    = (count_q >= CNT_W'(AF_LEVEL));
        flags.ae    = (count_q <= CNT_W'(AE_LEVEL));
    end

endmodule

// File: rtl/sync_fifo_occupancy_tracker.sv
// Multi-channel occupancy tracker for the PE-array synchronous FIFOs.
// Each channel is an independent sync_fifo_occ_channel; this level only
// packs/unpacks the per-channel vectors (channel c at [c*W +: W]).
// Optional macro SYNC_FIFO_OCC_PEAK_EN adds the peak output.
// Ports:
//   clk, reset                  clock (falling edge) and async active-high reset
//   clr[NUM_CH]                 per-channel synchronous clear
//   inc, inc_amt, dec, dec_amt  per-channel step requests and amounts
//   count                       per-channel occupancy
//   full, empty, almost_full, almost_empty  per-channel flags
//   overflow, underflow         per-channel sticky clamp indicators
//   peak                        (SYNC_FIFO_OCC_PEAK_EN only) per-channel maximum
module sync_fifo_occupancy_tracker
    import sync_fifo_occ_pkg::*;
#(
    parameter int unsigned NUM_CH   = 4,
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned STEP_W   = 3,
    parameter int          AF_LEVEL = int'(DEPTH) - 2,
    parameter int          AE_LEVEL = 2,
    localparam int unsigned CNT_W   = occ_cnt_w(DEPTH)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_CH-1:0]        clr,
    input  logic [NUM_CH-1:0]        inc,
    input  logic [NUM_CH*STEP_W-1:0] inc_amt,
    input  logic [NUM_CH-1:0]        dec,
    input  logic [NUM_CH*STEP_W-1:0] dec_amt,
    output logic [NUM_CH*CNT_W-1:0]  count,
    output logic [NUM_CH-1:0]        full,
    output logic [NUM_CH-1:0]        empty,
    output logic [NUM_CH-1:0]        almost_full,
    output logic [NUM_CH-1:0]        almost_empty,
    output logic [NUM_CH-1:0]        overflow,
    output logic [NUM_CH-1:0]        underflow
`ifdef SYNC_FIFO_OCC_PEAK_EN
    ,
    output logic [NUM_CH*CNT_W-1:0]  peak
`endif
);

    if (DEPTH < 1) begin : g_bad_depth
        $error("DEPTH must be >= 1");
    end
    if (AF_LEVEL < 0 || AF_LEVEL > int'(DEPTH)) begin : g_bad_af
        $error("AF_LEVEL must be in 0..DEPTH");
    end
    if (AE_LEVEL < 0 || AE_LEVEL > int'(DEPTH)) begin : g_bad_ae
        $error("AE_LEVEL must be in 0..DEPTH");
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        occ_flags_t flags;

        sync_fifo_occ_channel #(
            .DEPTH    (DEPTH),
            .STEP_W   (STEP_W),
            .AF_LEVEL (AF_LEVEL),
            .AE_LEVEL (AE_LEVEL),
            .CNT_W    (CNT_W)
        ) u_channel (
            .clk       (clk),
            .reset     (reset),
            .clr       (clr[c]),
            .inc       (inc[c]),
            .inc_amt   (inc_amt[c*STEP_W +: STEP_W]),
            .dec       (dec[c]),
            .dec_amt   (dec_amt[c*STEP_W +: STEP_W]),
            .count     (count[c*CNT_W +: CNT_W]),
            .flags     (flags),
            .overflow  (overflow[c]),
            .underflow (underflow[c])
`ifdef SYNC_FIFO_OCC_PEAK_EN
            ,
            .peak      (peak[c*CNT_W +: CNT_W])
`endif
        );

        assign full[c]         = flags.full;
        assign empty[c]        = flags.empty;
        assign almost_full[c]  = flags.af;
        assign almost_empty[c] = flags.ae;
    end

endmodule

// File: doc/sync_fifo_occupancy_tracker.md
Name: sync_fifo_occupancy_tracker

Overview:
Multi-channel occupancy tracker for the PE-array synchronous FIFOs. It replaces per-FIFO single-step up/down counters. Each channel keeps a bounded occupancy count that updates by runtime step amounts, so burst push and burst pop are supported. Each channel also provides full/empty/almost flags and sticky overflow/underflow errors, read by the FIFO control and the PE-array status logic.

Parameters:
NUM_CH, 4, number of independent channels
DEPTH, 16, maximum occupancy per channel (count range 0..DEPTH)
STEP_W, 3, width of the per-channel inc/dec amount (max step 2^STEP_W-1)
AF_LEVEL, DEPTH-2, almost_full asserted when count >= AF_LEVEL
AE_LEVEL, 2, almost_empty asserted when count <= AE_LEVEL
CNT_W, $clog2(DEPTH+1), derived count width; not to be overridden

Ports:
clk  in  1  clock; all state updates on the falling edge
reset  in  1  reset, asynchronous, active-high
clr  in  NUM_CH  per-channel synchronous clear
inc  in  NUM_CH  per-channel increment request
inc_amt  in  NUM_CH*STEP_W  per-channel increment amount; channel c occupies bits [c*STEP_W +: STEP_W]
dec  in  NUM_CH  per-channel decrement request
dec_amt  in  NUM_CH*STEP_W  per-channel decrement amount, same packing as inc_amt
count  out  NUM_CH*CNT_W  per-channel occupancy, same packing scheme
full  out  NUM_CH  count == DEPTH
empty  out  NUM_CH  count == 0
almost_full  out  NUM_CH  count >= AF_LEVEL
almost_empty  out  NUM_CH  count <= AE_LEVEL
overflow  out  NUM_CH  sticky: an update was clamped at DEPTH
underflow  out  NUM_CH  sticky: an update was clamped at 0

Behaviour:
- State per channel is count[CNT_W] plus the overflow and underflow bits. All state updates on the falling clk edge.
- Reset (async, active-high) sets count=0, overflow=0, underflow=0. Flags then read empty=1, almost_empty=1, full=0, almost_full=0 (almost_full=0 provided AF_LEVEL>0).
- Flags are combinational decodes of the count register. They change in the same half-cycle as count, with no extra latency.
- Per-channel priority, evaluated each falling edge:
  1) clr=1: count=0, overflow=0, underflow=0. inc/dec are ignored that edge.
  2) Otherwise: next = count + (inc ? inc_amt : 0) - (dec ? dec_amt : 0).
- Arithmetic for next: signed, width CNT_W+STEP_W+1, so no wrap can occur.
- Clamping of next:
  - next > DEPTH: count=DEPTH, overflow set to 1.
  - next < 0: count=0, underflow set to 1.
  - Otherwise count=next; overflow/underflow unchanged (sticky until clr or reset).
- Simultaneous inc and dec: only the net result is checked. For example, a full channel with inc=2 and dec=2 stays full with no overflow.
- Amount 0 with the request asserted is legal: no change, no error.
- inc/dec deasserted: the corresponding amt is don't-care.
- Channels are fully independent. Activity on one channel never affects another.
- Reset asserted mid-operation overrides everything immediately, regardless of clk.
- Elaboration checks, failing with $error:
  - AF_LEVEL must be in 0..DEPTH.
  - AE_LEVEL must be in 0..DEPTH.
  - DEPTH must be >= 1.

Optional Feature:
Macro: SYNC_FIFO_OCC_PEAK_EN.
- Defined: adds output peak (NUM_CH*CNT_W, packed like count). It holds the per-channel maximum count since the last reset/clr and updates on the same edge as count. Reset/clr set it to 0. It captures the post-clamp value, so its maximum is DEPTH.
- Undefined: the port and its registers are absent. All other behaviour is identical.

Decomposition:
- Package sync_fifo_occ_pkg holds:
  - function occ_cnt_w(depth) returning $clog2(depth+1)
  - localparam-style typedef occ_flags_t, a struct of full/empty/af/ae
  - the shared clamp-result enum {OCC_OK, OCC_OVF, OCC_UNF}
- Sub-module sync_fifo_occ_channel holds one channel's count, sticky bits, clamp logic and optional peak register.
- The top instantiates it NUM_CH times in a generate loop and packs/unpacks the port vectors.

Test Plan:
(All cases use NUM_CH=4, DEPTH=8, STEP_W=3, AF=6, AE=2 unless noted.)
- Reset released -> all count=0, empty=1, almost_empty=1, full=0, no errors. Assert reset mid-burst -> count is 0 immediately, before the next clk edge.
- ch0 inc_amt=3 for three falling edges -> count 3,6,8. almost_full rises at 6, full at 8, overflow=1 on the third edge (9 clamped to 8).
- ch1 at count 2, dec_amt=5 -> count=0, underflow=1, empty=1. Then inc_amt=1 -> count=1 with underflow still 1. clr -> count=0, underflow=0.
- ch2 at 8 (full), inc=2 and dec=2 same edge -> count stays 8, overflow=0. At 0, inc=1 and dec=3 -> count 0, underflow=1.
- All four channels driven with distinct random inc/dec/clr for 1000 edges -> each count matches a scoreboard model. No cross-channel disturbance.
- With SYNC_FIFO_OCC_PEAK_EN: ch3 counts 0→5→2 -> peak stays 5. clr -> peak=0.
